// File: rtl/dram_app_responder.sv
// dram_app_responder: DRAM side of the application interface.
// Requests are queued in order. Writes retire one per cycle into a word store.
// Reads wait a fixed latency and are then held until the initiator takes them.
module dram_app_responder #(
  parameter int APP_ADDR_WIDTH   = 28,
  parameter int APP_DATA_WIDTH   = 128,
  parameter int APP_MASK_WIDTH   = 16,
  parameter int MEM_WORDS_LOG2   = 10,
  parameter int READ_LATENCY     = 8,
  parameter int CALIB_CYCLES     = 16,
  parameter int QUEUE_DEPTH_LOG2 = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_ren,
  input  logic                      i_wen,
  input  logic [APP_ADDR_WIDTH-2:0] i_addr,
  input  logic [APP_DATA_WIDTH-1:0] i_data,
  input  logic [APP_MASK_WIDTH-1:0] i_mask,
  input  logic                      i_busy,
  output logic                      o_init_calib_complete,
  output logic [APP_DATA_WIDTH-1:0] o_data,
  output logic                      o_data_valid,
  output logic                      o_busy
);

  localparam int QUEUE_DEPTH = 1 << QUEUE_DEPTH_LOG2;
  localparam int MEM_WORDS   = 1 << MEM_WORDS_LOG2;
  localparam int CAL_W       = $clog2(CALIB_CYCLES + 1);
  localparam int LAT_W       = $clog2(READ_LATENCY + 1);

  // The flag is registered, so it must be set one cycle before it is seen.
  // That is why the last counter value is CALIB_CYCLES-2.
  localparam logic [CAL_W-1:0] CALIB_LAST =
    CAL_W'((CALIB_CYCLES >= 2) ? (CALIB_CYCLES - 2) : 0);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(READ_LATENCY - 1);
  localparam logic [QUEUE_DEPTH_LOG2:0] CNT_FULL = (QUEUE_DEPTH_LOG2 + 1)'(QUEUE_DEPTH);

  typedef struct packed {
    logic                      is_write;
    logic [MEM_WORDS_LOG2-1:0] idx;
    logic [APP_DATA_WIDTH-1:0] data;
    logic [APP_MASK_WIDTH-1:0] mask;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_WAIT = 2'd1,
    READ_HOLD = 2'd2
  } state_t;

  // Storage
  logic [APP_DATA_WIDTH-1:0]   mem_r [MEM_WORDS];
  entry_t                      queue_r [QUEUE_DEPTH];
  logic [QUEUE_DEPTH_LOG2-1:0] wr_ptr_r;
  logic [QUEUE_DEPTH_LOG2-1:0] rd_ptr_r;
  logic [QUEUE_DEPTH_LOG2:0]   count_r;

  // Calibration and execution state
  logic [CAL_W-1:0]          calib_cnt_r;
  logic                      calib_r;
  state_t                    state_r;
  logic [LAT_W-1:0]          lat_cnt_r;
  logic [MEM_WORDS_LOG2-1:0] rd_idx_r;
  logic [APP_DATA_WIDTH-1:0] data_r;

  entry_t push_entry_s;
  entry_t head_s;
  logic   accept_s;
  logic   pop_s;
  logic   mem_we_s;
  logic   unused_addr_s;

  // Address bits outside the word index are ignored, so the store aliases.
  assign unused_addr_s = ^{i_addr[APP_ADDR_WIDTH-2:MEM_WORDS_LOG2+3], i_addr[2:0]};

  // Build the queue entry. A simultaneous read and write becomes a write.
  always_comb begin
    push_entry_s          = '0;
    push_entry_s.is_write = i_wen;
    push_entry_s.idx      = i_addr[MEM_WORDS_LOG2+2:3];
    push_entry_s.data     = i_data;
    push_entry_s.mask     = i_mask;
  end

  assign head_s   = queue_r[rd_ptr_r];
  assign o_busy   = ~calib_r | (count_r == CNT_FULL);
  assign accept_s = (i_ren | i_wen) & ~o_busy;
  assign pop_s    = (state_r == IDLE) && (count_r != '0);
  // Gate with reset so that a queued write does not land on a reset edge.
  assign mem_we_s = pop_s & head_s.is_write & i_rst_n;

  assign o_init_calib_complete = calib_r;
  assign o_data                = data_r;
  assign o_data_valid          = (state_r == READ_HOLD) & ~i_busy;

  // Count calibration cycles after reset release, then latch complete.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      calib_cnt_r <= '0;
      calib_r     <= 1'b0;
    end else if (!calib_r) begin
      calib_cnt_r <= calib_cnt_r + CAL_W'(1);
      if (calib_cnt_r == CALIB_LAST) begin
        calib_r <= 1'b1;
      end
    end
  end

  // Queue slot storage. This has no reset; the pointers decide what is valid.
  always_ff @(posedge i_clk) begin
    if (accept_s) begin
      queue_r[wr_ptr_r] <= push_entry_s;
    end
  end

  // Queue pointers and occupancy. A push and a pop may happen together.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (accept_s) begin
        wr_ptr_r <= wr_ptr_r + QUEUE_DEPTH_LOG2'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + QUEUE_DEPTH_LOG2'(1);
      end
      case ({accept_s, pop_s})
        2'b10:   count_r <= count_r + (QUEUE_DEPTH_LOG2 + 1)'(1);
        2'b01:   count_r <= count_r - (QUEUE_DEPTH_LOG2 + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Byte-masked write of the queue head. A mask bit of 1 keeps the old byte.
  always_ff @(posedge i_clk) begin
    if (mem_we_s) begin
      for (int b = 0; b < APP_MASK_WIDTH; b++) begin
        if (!head_s.mask[b]) begin
          mem_r[head_s.idx][8*b +: 8] <= head_s.data[8*b +: 8];
        end
      end
    end
  end

  // Read engine: latency countdown, fetch from the store, hold until taken.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r   <= IDLE;
      lat_cnt_r <= '0;
      rd_idx_r  <= '0;
      data_r    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pop_s && !head_s.is_write) begin
            rd_idx_r  <= head_s.idx;
            lat_cnt_r <= LAT_INIT;
            state_r   <= READ_WAIT;
          end
        end
        READ_WAIT: begin
          if (lat_cnt_r == '0) begin
            data_r  <= mem_r[rd_idx_r];
            state_r <= READ_HOLD;
          end else begin
            lat_cnt_r <= lat_cnt_r - LAT_W'(1);
          end
        end
        READ_HOLD: begin
          if (!i_busy) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_app_responder.sv
// Directed testbench for dram_app_responder.
// Inputs are driven 1 time unit after the rising edge.
// Outputs are sampled on the falling edge.
module tb_dram_app_responder;

  logic         i_clk;
  logic         i_rst_n;
  logic         i_ren;
  logic         i_wen;
  logic [26:0]  i_addr;
  logic [127:0] i_data;
  logic [15:0]  i_mask;
  logic         i_busy;
  logic         o_init_calib_complete;
  logic [127:0] o_data;
  logic         o_data_valid;
  logic         o_busy;

  int vectors     = 0;
  int miscompares = 0;

  logic         obs_valid;
  logic [127:0] obs_data;
  logic         obs_busy;
  logic         obs_calib;
  logic [127:0] rx_q [$];

  localparam logic [127:0] D2 = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [127:0] D6 = 128'hCAFEBABE_DEADBEEF_01234567_89ABCDEF;
  localparam logic [127:0] DX = 128'h55555555_12345678_9ABCDEF0_55555555;

  dram_app_responder dut (
    .i_clk                 (i_clk),
    .i_rst_n               (i_rst_n),
    .i_ren                 (i_ren),
    .i_wen                 (i_wen),
    .i_addr                (i_addr),
    .i_data                (i_data),
    .i_mask                (i_mask),
    .i_busy                (i_busy),
    .o_init_calib_complete (o_init_calib_complete),
    .o_data                (o_data),
    .o_data_valid          (o_data_valid),
    .o_busy                (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample this cycle's outputs, then move to the drive point of the next cycle.
  task automatic step();
    #4;
    obs_valid = o_data_valid;
    obs_data  = o_data;
    obs_busy  = o_busy;
    obs_calib = o_init_calib_complete;
    if (obs_valid) rx_q.push_back(obs_data);
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_write(input logic [26:0] a, input logic [127:0] d,
                          input logic [15:0] m, input string tag);
    bit ok;
    ok     = 1'b0;
    i_wen  = 1'b1;
    i_addr = a;
    i_data = d;
    i_mask = m;
    for (int i = 0; i < 40 && !ok; i++) begin
      step();
      if (!obs_busy) ok = 1'b1;
    end
    i_wen = 1'b0;
    chk({tag, "_wr_accept"}, 128'(ok), 128'd1);
  endtask

  task automatic read_expect(input logic [26:0] a, input logic [127:0] exp,
                             input bit check_lat, input string tag);
    bit           found;
    int           lat;
    logic [127:0] got;
    found  = 1'b0;
    lat    = 0;
    got    = '0;
    i_ren  = 1'b1;
    i_addr = a;
    step();
    chk({tag, "_rd_accept"}, 128'(obs_busy), 128'd0);
    i_ren = 1'b0;
    for (int i = 1; i <= 60 && !found; i++) begin
      step();
      if (obs_valid) begin
        found = 1'b1;
        lat   = i;
        got   = obs_data;
      end
    end
    chk({tag, "_found"}, 128'(found), 128'd1);
    chk({tag, "_data"}, got, exp);
    if (check_lat) chk({tag, "_latency"}, 128'(lat), 128'd10);
    step();
    chk({tag, "_single"}, 128'(obs_valid), 128'd0);
  endtask

  initial begin
    bit ok;
    int valid_seen;
    i_rst_n = 1'b0;
    i_ren   = 1'b0;
    i_wen   = 1'b0;
    i_addr  = '0;
    i_data  = '0;
    i_mask  = '0;
    i_busy  = 1'b0;
    @(posedge i_clk);
    #1;

    // 1: reset values, then calibration timing
    repeat (3) step();
    chk("rst_calib", 128'(obs_calib), 128'd0);
    chk("rst_busy",  128'(obs_busy),  128'd1);
    chk("rst_valid", 128'(obs_valid), 128'd0);
    chk("rst_data",  obs_data,        128'd0);
    i_rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("calib_c%0d", k), 128'(obs_calib), 128'(k >= 16));
      chk($sformatf("busy_c%0d", k),  128'(obs_busy),  128'(k < 16));
    end

    // 2: full write, then a read into an idle engine (latency of 10)
    do_write(27'h40, D2, 16'h0000, "t2");
    step();
    step();
    read_expect(27'h40, D2, 1'b1, "t2");

    // 3: masked write; only bytes 0-3 are updated
    do_write(27'h80, {16{8'hAA}}, 16'h0000, "t3a");
    do_write(27'h80, {16{8'h11}}, 16'hFFF0, "t3b");
    step();
    step();
    read_expect(27'h80, 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_11111111, 1'b0, "t3");

    // 4: a read back-pressures the queue; the 5th new read is refused, then retried
    for (int i = 0; i < 5; i++) begin
      do_write(27'h100 + 27'(8 * i), 128'(i + 1), 16'h0000, $sformatf("t4pre%0d", i));
    end
    repeat (4) step();
    rx_q.delete();
    i_ren  = 1'b1;
    i_addr = 27'h40;
    step();
    chk("t4_lead_accept", 128'(obs_busy), 128'd0);
    for (int i = 0; i < 4; i++) begin
      i_addr = 27'h100 + 27'(8 * i);
      step();
      chk($sformatf("t4_accept%0d", i + 1), 128'(obs_busy), 128'd0);
    end
    i_addr = 27'h120;
    step();
    chk("t4_busy_full", 128'(obs_busy), 128'd1);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      step();
      if (!obs_busy) ok = 1'b1;
    end
    i_ren = 1'b0;
    chk("t4_retry_accept", 128'(ok), 128'd1);
    for (int i = 0; i < 200 && rx_q.size() < 6; i++) step();
    chk("t4_count", 128'(rx_q.size()), 128'd6);
    if (rx_q.size() >= 6) begin
      chk("t4_lead", rx_q[0], D2);
      for (int i = 1; i <= 5; i++) chk($sformatf("t4_order%0d", i), rx_q[i], 128'(i));
    end
    step();

    // 5: initiator busy across the ready cycle and 3 more cycles
    i_busy = 1'b1;
    i_ren  = 1'b1;
    i_addr = 27'h100;
    step();
    chk("t5_accept", 128'(obs_busy), 128'd0);
    i_ren = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      step();
      chk($sformatf("t5_novalid_c%0d", k), 128'(obs_valid), 128'd0);
      if (k >= 10) chk($sformatf("t5_hold_c%0d", k), obs_data, 128'd1);
    end
    i_busy = 1'b0;
    step();
    chk("t5_valid", 128'(obs_valid), 128'd1);
    chk("t5_data",  obs_data,        128'd1);
    step();
    chk("t5_single", 128'(obs_valid), 128'd0);

    // 6a: write, then a read of the same word in the next cycle
    do_write(27'h200, D6, 16'h0000, "t6a");
    read_expect(27'h200, D6, 1'b0, "t6a");

    // 6b: reset during READ_WAIT drops the read; the store keeps its data
    do_write(27'h280, DX, 16'h0000, "t6b");
    step();
    step();
    i_ren  = 1'b1;
    i_addr = 27'h280;
    step();
    i_ren = 1'b0;
    repeat (3) step();
    i_rst_n = 1'b0;
    step();
    step();
    chk("t6b_rst_calib", 128'(obs_calib), 128'd0);
    chk("t6b_rst_busy",  128'(obs_busy),  128'd1);
    chk("t6b_rst_data",  obs_data,        128'd0);
    i_rst_n    = 1'b1;
    valid_seen = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (obs_valid) valid_seen++;
    end
    chk("t6b_no_valid", 128'(valid_seen), 128'd0);
    chk("t6b_recal",    128'(obs_calib),  128'd1);
    read_expect(27'h280, DX, 1'b1, "t6b");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
